// File: rtl/dense_result_pcim_writer.sv
// Drains 512-bit dense_layer_core results into 64-byte single-beat AXI4 writes on PCIM.
// Latency: a buffered result is presented on AW/W the cycle after the previous write retires; at most one write per 2 cycles.
// Backpressure: in_ready drops when the buffer is full or the job quota is met. AW is held at MAX_OUTSTANDING. Optional irq pulse: DENSE_WR_IRQ_EN.
module dense_result_pcim_writer #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [15:0] AXI_ID          = 16'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  base_addr,
  input  logic [15:0]  num_results,
  input  logic [511:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         irq,
  output logic [15:0]  results_written
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [8:0] MAX_OUT = 9'(MAX_OUTSTANDING);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state;
  logic [57:0]  base_hi;
  logic [15:0]  num_lat;
  logic [15:0]  accepted;
  logic [15:0]  issued;
  logic [8:0]   outstanding;
  logic         pend;
  logic [511:0] mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  logic fifo_full, fifo_empty, run, push, aw_hs, w_hs, b_hs, complete, present, done_set;
  logic unused_bits;

  // Fixed AXI attributes: one full 64-byte beat, INCR, always accepting responses.
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'd6;
  assign awburst = 2'b01;
  assign wstrb   = {64{1'b1}};
  assign wlast   = 1'b1;
  assign bready  = 1'b1;
  // The response id and the sub-line address bits carry no information here.
  assign unused_bits = ^{bid, base_addr[5:0]};

  assign run        = (state == ST_RUN);
  assign busy       = run;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = run && !fifo_full && (accepted < num_lat);
  assign push       = in_valid && in_ready;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid && bready;
  // A write retires once each channel has either already handshaken or does so now.
  assign complete   = pend && (!awvalid || aw_hs) && (!wvalid || w_hs);
  assign present    = run && !pend && !fifo_empty && (issued < num_lat) && (outstanding < MAX_OUT);
  assign done_set   = (!run && start && (num_results == 16'd0)) ||
                      (run && b_hs && ((results_written + 16'd1) == num_lat));

  // Result buffer storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Job control, write issue, outstanding tracking and B-channel accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      base_hi         <= '0;
      num_lat         <= '0;
      accepted        <= '0;
      issued          <= '0;
      outstanding     <= '0;
      pend            <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      awvalid         <= 1'b0;
      wvalid          <= 1'b0;
      awaddr          <= '0;
      wdata           <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      results_written <= '0;
    end else begin
      done <= done_set;
      if (!run) begin
        // Responses arriving while idle are consumed without touching any counter.
        if (start && (num_results != 16'd0)) begin
          state           <= ST_RUN;
          base_hi         <= base_addr[63:6];
          num_lat         <= num_results;
          accepted        <= '0;
          issued          <= '0;
          outstanding     <= '0;
          err             <= 1'b0;
          results_written <= '0;
        end
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + (AW+1)'(1);
          accepted <= accepted + 16'd1;
        end
        if (present) begin
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          pend    <= 1'b1;
          awaddr  <= {base_hi + {42'd0, issued}, 6'd0};
          wdata   <= mem[rd_ptr[AW-1:0]];
        end
        if (aw_hs) awvalid <= 1'b0;
        if (w_hs)  wvalid  <= 1'b0;
        if (complete) begin
          pend   <= 1'b0;
          rd_ptr <= rd_ptr + (AW+1)'(1);
          issued <= issued + 16'd1;
        end
        if (aw_hs && !b_hs)      outstanding <= outstanding + 9'd1;
        else if (!aw_hs && b_hs) outstanding <= outstanding - 9'd1;
        if (b_hs) begin
          results_written <= results_written + 16'd1;
          if (bresp != 2'b00) err <= 1'b1;
          if ((results_written + 16'd1) == num_lat) state <= ST_IDLE;
        end
      end
    end
  end

`ifdef DENSE_WR_IRQ_EN
  // Completion interrupt tracks done exactly, including zero-length jobs.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= done_set;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dense_result_pcim_writer.sv
// Directed bench for dense_result_pcim_writer with a scoreboarded PCIM slave model.
// Expected addresses and data are queued when results are accepted and are compared at the AW/W handshakes.
// The slave model controls ready/B timing. The main block runs the directed job sequence.
module tb_dense_result_pcim_writer;

  localparam int MAXO = 2;
`ifdef DENSE_WR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [63:0]  base_addr = '0;
  logic [15:0]  num_results = '0;
  logic [511:0] in_data = '0;
  logic         in_ready, awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
  logic [15:0]  awid, bid = '0, results_written;
  logic [63:0]  awaddr, wstrb;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst, bresp = 2'b00;
  logic [511:0] wdata;
  logic         bvalid = 1'b0, bready, busy, done, err, irq;

  dense_result_pcim_writer #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(MAXO), .AXI_ID(16'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_results(num_results),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .done(done), .err(err), .irq(irq), .results_written(results_written)
  );

  int n_tests = 0, n_fail = 0;
  logic [63:0]  exp_addr [$];
  logic [511:0] exp_data [$];
  int bq [$];
  bit armed = 0, aw_en = 1, w_en = 1, b_hold = 0, spurious_b = 0;
  int b_lat = 2, cyc = 0, aw_cnt = 0, w_cnt = 0, b_pushed = 0, b_sent = 0, bad_b = -1, done_cnt = 0;
  int seq = 1, job_idx = 0, got = 0;
  logic [63:0] job_base = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] gen(input int s);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(s) * 32'h9E3779B1 + 32'(i) * 32'h01000193 + 32'h5A;
    return d;
  endfunction

  // PCIM slave model: readies, delayed B responses, handshake scoreboard, done/irq monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        cyc++;
        awready = aw_en;
        wready  = w_en;
        if (spurious_b) begin
          bvalid = 1'b1; bresp = 2'b00; spurious_b = 0;
        end else if (!b_hold && bq.size() > 0 && bq[0] <= cyc) begin
          void'(bq.pop_front());
          bvalid = 1'b1;
          bresp  = (b_sent == bad_b) ? 2'b10 : 2'b00;
          b_sent++;
        end else begin
          bvalid = 1'b0; bresp = 2'b00;
        end
        if (awvalid && awready) begin
          chk("aw_queued", exp_addr.size() != 0, 1);
          if (exp_addr.size() != 0) chk("awaddr", awaddr, exp_addr.pop_front());
          chk("aw_attr", {awid, awlen, awsize, awburst}, {16'd0, 8'd0, 3'd6, 2'b01});
          aw_cnt++;
        end
        if (wvalid && wready) begin
          chk("w_queued", exp_data.size() != 0, 1);
          if (exp_data.size() != 0) chk("wdata", wdata, exp_data.pop_front());
          chk("w_attr", {wstrb, wlast}, {{64{1'b1}}, 1'b1});
          w_cnt++;
        end
        while (b_pushed < ((aw_cnt < w_cnt) ? aw_cnt : w_cnt)) begin
          bq.push_back(cyc + b_lat);
          b_pushed++;
        end
        if (done) done_cnt++;
        chk("irq", irq, IRQ_ON && done);
      end
    end
  end

  task automatic do_start(input logic [63:0] base, input logic [15:0] num);
    aw_cnt = 0; w_cnt = 0; b_pushed = 0; done_cnt = 0; job_idx = 0;
    job_base = {base[63:6], 6'd0};
    start = 1'b1; base_addr = base; num_results = num;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input int n, input int budget, output int cnt);
    cnt = 0;
    for (int c = 0; c < budget && cnt < n; c++) begin
      in_valid = 1'b1;
      in_data  = gen(seq);
      if (in_ready) begin
        exp_data.push_back(gen(seq));
        exp_addr.push_back(job_base + 64'(job_idx) * 64'd64);
        job_idx++; seq++; cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_flags", {in_ready, awvalid, wvalid, busy, done, err, irq, bready}, 8'b0000_0001);
    chk("rst_results", results_written, 16'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    chk("rst_wdata", wdata, 512'd0);
    rst = 1'b0; armed = 1;
    @(negedge clk);

    // Basic 3-result job
    do_start(64'h1000_0040, 16'd3);
    chk("t1_busy", busy, 1'b1);
    push(3, 20, got);
    chk("t1_pushed", got, 3);
    wait_done(200);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_results", results_written, 16'd3);
    chk("t1_err", err, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_aw_cnt", aw_cnt, 3);
    // Spurious B while idle
    spurious_b = 1;
    repeat (4) @(negedge clk);
    chk("spur_results", results_written, 16'd3);
    chk("spur_busy", busy, 1'b0);

    // AW stalled: buffer fills at 4, then drains in order
    aw_en = 0;
    do_start(64'h0000_0000_0000_2000, 16'd5);
    push(5, 10, got);
    chk("t2_pushed_full", got, 4);
    chk("t2_in_ready", in_ready, 1'b0);
    aw_en = 1;
    push(1, 40, got);
    chk("t2_pushed_rest", got, 1);
    wait_done(300);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_results", results_written, 16'd5);
    chk("t2_aw_w", {32'(aw_cnt), 32'(w_cnt)}, {32'd5, 32'd5});

    // Outstanding limit with B withheld
    b_hold = 1;
    do_start(64'h0000_0000_0000_3000, 16'd3);
    push(3, 30, got);
    repeat (15) @(negedge clk);
    chk("t3_aw_cnt_held", aw_cnt, 2);
    chk("t3_awvalid_held", awvalid, 1'b0);
    chk("t3_results_held", results_written, 16'd0);
    b_hold = 0;
    wait_done(300);
    chk("t3_aw_cnt", aw_cnt, 3);
    chk("t3_results", results_written, 16'd3);

    // W before AW, then AW before W
    aw_en = 0; w_en = 1;
    do_start(64'h0000_0000_0000_4000, 16'd2);
    push(2, 10, got);
    repeat (4) @(negedge clk);
    chk("t4a_cnts", {32'(aw_cnt), 32'(w_cnt)}, {32'd0, 32'd1});
    chk("t4a_valids", {awvalid, wvalid}, 2'b10);
    aw_en = 1; w_en = 0;
    repeat (6) @(negedge clk);
    chk("t4b_cnts", {32'(aw_cnt), 32'(w_cnt)}, {32'd2, 32'd1});
    chk("t4b_valids", {awvalid, wvalid}, 2'b01);
    w_en = 1;
    wait_done(300);
    chk("t4_results", results_written, 16'd2);
    chk("t4_done_cnt", done_cnt, 1);

    // Error response on the 2nd B
    bad_b = b_sent + 1;
    do_start(64'h0000_0000_0000_5000, 16'd3);
    push(3, 30, got);
    wait_done(300);
    chk("t5_err", err, 1'b1);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_results", results_written, 16'd3);
    bad_b = -1;

    // Zero-length job
    do_start(64'h0000_0000_0000_9000, 16'd0);
    chk("t6_done", done, 1'b1);
    chk("t6_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_aw_cnt", aw_cnt, 0);

    // Address wrap past 2^64; err cleared by the new job
    do_start(64'hFFFF_FFFF_FFFF_FFC0, 16'd2);
    chk("t7_err_clr", err, 1'b0);
    push(2, 20, got);
    wait_done(300);
    chk("t7_results", results_written, 16'd2);
    chk("t7_queue_empty", exp_addr.size(), 0);

    // Reset in the middle of a job
    aw_en = 0;
    do_start(64'h0000_0000_0000_6000, 16'd4);
    push(3, 20, got);
    chk("t8_awvalid_pre", awvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_after_rst", {awvalid, wvalid, busy, in_ready}, 4'b0000);
    rst = 1'b0;
    exp_addr.delete(); exp_data.delete(); bq.delete();
    aw_en = 1; b_hold = 0;
    repeat (2) @(negedge clk);

    // Recovery job after reset
    do_start(64'h0000_0000_0000_7000, 16'd1);
    push(1, 20, got);
    wait_done(200);
    chk("t9_results", results_written, 16'd1);
    chk("t9_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
